// File: rtl/pipelined_addsub_nbit_pkg.sv
// Shared constants for the pipelined adder/subtractor and the ALU decoder.
// Default geometry plus the add/sub mode encoding.
package pipelined_addsub_nbit_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SEG   = 4;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

endpackage

// File: rtl/adder_segment.sv
// Combinational SEG-bit ripple adder built from full_adder cells.
// Also exposes the carry into its top bit for overflow detection.
module adder_segment
    import pipelined_addsub_nbit_pkg::*;
#(
    parameter int SEG = DEF_SEG
) (
    input  logic [SEG-1:0] i_a,
    input  logic [SEG-1:0] i_b,
    input  logic           i_cin,
    output logic [SEG-1:0] o_s,
    output logic           o_cout,
    output logic           o_c_msb_in
);

    logic [SEG:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar i = 0; i < SEG; i++) begin : g_bit
        full_adder u_fa (
            .i_a (i_a[i]),
            .i_b (i_b[i]),
            .i_c (w_c[i]),
            .o_s (o_s[i]),
            .o_c (w_c[i+1])
        );
    end

    assign o_cout     = w_c[SEG];
    assign o_c_msb_in = w_c[SEG-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
// Building block for the ripple segments.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

// File: rtl/pipelined_addsub_nbit.sv
// Pipelined ripple-carry adder/subtractor, one SEG-bit segment per stage.
// Operands are skewed forward, finished sum segments deskewed alongside.
module pipelined_addsub_nbit
    import pipelined_addsub_nbit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    input  logic             sub,
    output logic             out_valid,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             Ovf
);

    localparam int NSTG = WIDTH / SEG;
    localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG{1'b1}});

    logic [WIDTH-1:0] w_be;
    logic             w_c0;

    logic [WIDTH-1:0] r_a [NSTG];
    logic [WIDTH-1:0] r_b [NSTG];
    logic [WIDTH-1:0] r_s [NSTG];
    logic             r_c [NSTG];
    logic             r_v [NSTG];
    logic             r_ovf;

    logic [SEG-1:0]   w_sa [NSTG];
    logic [SEG-1:0]   w_sb [NSTG];
    logic [SEG-1:0]   w_ss [NSTG];
    logic             w_ci [NSTG];
    logic             w_co [NSTG];
    logic             w_cm [NSTG];
    logic [WIDTH-1:0] w_sn [NSTG];

    // Mode is folded into the operands here, so each op carries its own.
    assign w_be = B ^ {WIDTH{sub}};
    assign w_c0 = (mode_e'(sub) == MODE_SUB) ? 1'b1 : Ci;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        if (k == 0) begin : g_first
            assign w_sa[k] = A[SEG-1:0];
            assign w_sb[k] = w_be[SEG-1:0];
            assign w_ci[k] = w_c0;
            assign w_sn[k] = WIDTH'(w_ss[k]);
        end else begin : g_next
            assign w_sa[k] = r_a[k-1][k*SEG +: SEG];
            assign w_sb[k] = r_b[k-1][k*SEG +: SEG];
            assign w_ci[k] = r_c[k-1];
            assign w_sn[k] = (r_s[k-1] & ~(SEG_MASK << (k*SEG)))
                           | (WIDTH'(w_ss[k]) << (k*SEG));
        end

        adder_segment #(
            .SEG (SEG)
        ) u_seg (
            .i_a        (w_sa[k]),
            .i_b        (w_sb[k]),
            .i_cin      (w_ci[k]),
            .o_s        (w_ss[k]),
            .o_cout     (w_co[k]),
            .o_c_msb_in (w_cm[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NSTG; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
                r_c[k] <= 1'b0;
                r_v[k] <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (en) begin
            r_a[0] <= A;
            r_b[0] <= w_be;
            r_s[0] <= w_sn[0];
            r_c[0] <= w_co[0];
            r_v[0] <= in_valid;
            for (int k = 1; k < NSTG; k++) begin
                r_a[k] <= r_a[k-1];
                r_b[k] <= r_b[k-1];
                r_s[k] <= w_sn[k];
                r_c[k] <= w_co[k];
                r_v[k] <= r_v[k-1];
            end
            r_ovf <= w_co[NSTG-1] ^ w_cm[NSTG-1];
        end
    end

    assign out_valid = r_v[NSTG-1];
    assign S         = r_s[NSTG-1];
    assign Co        = r_c[NSTG-1];
    assign Ovf       = r_ovf;

endmodule

// File: doc/pipelined_addsub_nbit.md
Name: pipelined_addsub_nbit

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor; the next generation of the 4-bit ripple carry adder.
- Splits a WIDTH-bit add or subtract into WIDTH/SEG ripple segments, with one registered segment per pipeline stage.
- Accepts one new operation per enabled cycle.
- Provides a carry flag and a signed overflow flag.
- Serves as the arithmetic core for the datapath ALU and for later adder comparison experiments.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of SEG.
- SEG, 4, bits added per pipeline stage (ripple length per stage).
- NSTG, WIDTH/SEG, derived (localparam), number of stages; this is also the latency in enabled cycles.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  pipeline advance enable; when 0, every pipeline register holds.
- in_valid  input  1  A, B, Ci and sub carry a valid operation this cycle.
- A  input  WIDTH  first operand.
- B  input  WIDTH  second operand.
- Ci  input  1  carry in; used only when sub=0.
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  S, Co and Ovf hold a valid result.
- S  output  WIDTH  sum or difference.
- Co  output  1  carry out of the MSB; when sub=1 this is the not-borrow flag (1 means A>=B unsigned).
- Ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (async, rst=1): every pipeline register clears; out_valid=0, S=0, Co=0, Ovf=0 immediately, without waiting for a clock. Reset mid-operation discards all in-flight operations, with no partial results. After rst deasserts, out_valid stays 0 until the first valid operation has moved NSTG enabled cycles.
- Operand conditioning at input:
  - Effective B: Be = B ^ {WIDTH{sub}}.
  - Effective carry in: c0 = sub ? 1 : Ci.
- Stage k (k = 0..NSTG-1):
  - Ripple-adds segment k of A and Be with the carry registered by stage k-1 (c0 for stage 0).
  - Registers the segment sum, the carry out, and the still-unprocessed upper segments of A and Be (skew).
  - Carries the already-computed lower sum segments forward (deskew).
  - Carries a valid bit forward alongside the data.
- Latency: an operation presented with in_valid=1 at enabled edge t appears on S/Co/Ovf with out_valid=1 after edge t+NSTG-1, i.e. NSTG enabled edges total. Throughput is one operation per enabled cycle.
- en=0: every register (data and valid) holds; outputs stay stable; inputs presented while en=0 are ignored.
- in_valid=0 at an enabled edge inserts a bubble: valid=0 propagates, and the data path still advances (its contents are don't-care). When out_valid=0, S/Co/Ovf values are don't-care, except after reset when they are 0.
- Arithmetic:
  - sub=0: {Co,S} = A + B + Ci.
  - sub=1: {Co,S} = A + ~B + 1, so S = (A - B) mod 2^WIDTH; Ci is ignored.
  - Ovf = carry into MSB XOR carry out of MSB. This holds for both modes; Ovf is meaningful only under signed interpretation.
- Wrap-around: results are modulo 2^WIDTH, with no saturation.
- Operations in flight are independent: the mode (sub) of each one is captured with it at entry, so back-to-back mixed add/sub operations must not interfere.
- WIDTH == SEG (NSTG=1) is legal: a single registered stage, latency 1.

Decomposition:
- Shared constants header: default WIDTH/SEG values and an ADD/SUB mode encoding (ADD=0, SUB=1), shared with the ALU decoder.
- One sub-module, adder_segment: combinational SEG-bit ripple adder built from the existing full_adder cells. It takes (a, b, cin) and returns (s, cout, c_msb_in); c_msb_in is the carry into its top bit, used for Ovf in the last stage.
- The top level instantiates NSTG adder_segment instances inside a generate loop, with skew/deskew registers between them.

Test Plan (WIDTH=16, SEG=4, NSTG=4):
- Reset check: rst pulse asserted mid-clock -> out_valid=0, S=0, Co=0, Ovf=0 immediately, without a clock edge; an operation in flight before reset never appears at the output.
- Carry ripple across all stages: A=16'hFFFF, B=16'h0000, Ci=1, sub=0, single valid -> after 4 edges S=16'h0000, Co=1, Ovf=0, out_valid high for exactly 1 cycle.
- Signed overflow: A=16'h7FFF, B=16'h0001, sub=0, Ci=0 -> S=16'h8000, Co=0, Ovf=1. Then A=16'h8000, B=16'h0001, sub=1 -> S=16'h7FFF, Co=1, Ovf=1.
- Borrow and Ci ignored: A=16'h0003, B=16'h0005, sub=1, Ci=1 -> S=16'hFFFE, Co=0, Ovf=0.
- Back-to-back mixed stream with a bubble: 8 consecutive valid ops alternating add/sub with random operands, one in_valid=0 cycle inserted -> results emerge in order, 4 cycles after entry, matching a reference model; the bubble appears as one out_valid=0 cycle.
- Stall: en=0 for 3 cycles while 4 ops are in flight -> outputs frozen; after en returns to 1, results resume with no loss or duplication, and inputs offered during the stall are dropped.
